mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one memory port between the core's instruction fetch bus and its load/store data bus. Requests are arbitrated round-robin, and each grant is forwarded to the memory. The owner of every in-flight transaction is tracked so that in-order responses can be routed back to the correct requester. Sits between the core (fetch unit, load/store unit) and the unified program/data memory.

Parameters:
ADDR_W, 32, address width of all three buses
DATA_W, 32, data width of all three buses
OUTST_DEPTH, 2, maximum in-flight memory transactions (owner FIFO depth, power of 2, >=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ibus_req  in  1  fetch request (read only), held until granted
ibus_addr  in  ADDR_W  fetch address
ibus_gnt  out  1  fetch request accepted this cycle
ibus_rvalid  out  1  fetch response valid
ibus_rdata  out  DATA_W  fetch response data
dbus_req  in  1  data request, held until granted
dbus_we  in  1  1 = write, 0 = read
dbus_be  in  DATA_W/8  write byte enables
dbus_addr  in  ADDR_W  data address
dbus_wdata  in  DATA_W  write data
dbus_gnt  out  1  data request accepted this cycle
dbus_rvalid  out  1  data response valid (read data or write ack)
dbus_rdata  out  DATA_W  data response
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_be  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  memory response valid (reads and writes), in order, latency >=1
mem_rdata  in  DATA_W  memory response data
proto_err  out  1  sticky: mem_rvalid arrived with no outstanding transaction

Behaviour:
- Clock is clk; reset is rst_n, synchronous and active-low. All state is sampled on the rising edge of clk.
- Reset values: last_owner = DBUS, owner FIFO empty (count 0), proto_err = 0.
- Reset outputs: ibus_rvalid = 0, dbus_rvalid = 0, ibus_gnt = 0, dbus_gnt = 0, mem_req = 0.
- Reset data outputs: ibus_rdata = 0, dbus_rdata = 0.
- Issue stage is combinational, from registered state:
  - can_issue = (count < OUTST_DEPTH). Full is judged on the registered count only; a pop in the same cycle does not free a slot.
  - Selection: if only one requester is active, select it. If both are active, select the one that is not last_owner.
  - mem_req = can_issue && (ibus_req || dbus_req).
  - mem_addr, mem_we, mem_be and mem_wdata are muxed from the selected requester. Fetch forces mem_we = 0 and mem_be = all ones.
  - ibus_gnt = mem_req && mem_gnt && sel==IBUS. dbus_gnt is defined likewise for sel==DBUS.
- Handshake:
  - A transfer occurs when mem_req && mem_gnt.
  - On a transfer: push the selected owner into the FIFO and set last_owner <= selected owner.
  - Requesters must hold req and all payload signals stable until their gnt is seen.
  - With no transfer, last_owner is unchanged.
- Response stage:
  - On mem_rvalid with FIFO non-empty: pop the head. Next cycle, assert the owner's rvalid for 1 cycle, and load its rdata from mem_rdata (registered, +1 cycle).
  - The non-owner's rvalid stays 0 and its rdata holds its previous value.
  - Total load-to-use latency is memory latency + 1.
- Push and pop in the same cycle: count is unchanged and the FIFO pointers both advance. This is legal even when full, but no push can occur when full.
- mem_rvalid with FIFO empty: response is dropped, no rvalid is asserted, and proto_err <= 1 (held until reset).
- Pointers wrap modulo OUTST_DEPTH, and count ranges 0..OUTST_DEPTH.
- Reset mid-operation: the FIFO is cleared and in-flight responses are abandoned. The memory is reset by the same rst_n.
- Write responses go to dbus_rvalid as acks. dbus_rdata loads mem_rdata regardless, and its value is don't-care for writes.

Decomposition:
- Package mem_arb_pkg holds `typedef enum logic {OWNER_IBUS, OWNER_DBUS} owner_t;`.
- Sub-module arb_owner_fifo: a synchronous FIFO of owner_t, with parameter DEPTH and ports push/pop/full/empty/head/count. It uses the same clk/rst_n as the arbiter.
- Arbitration, the issue mux and response routing stay in mem_bus_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both requesters active → no gnt, mem_req=0, both rvalid=0, both rdata=0, proto_err=0.
- Fetch only: ibus_req=1, addr 0x0, 0x4, 0x8; mem_gnt=1; memory latency 1 returning 0xA0, 0xA4, 0xA8 → ibus_gnt every cycle, ibus_rvalid 2 cycles after each grant with matching data, dbus_rvalid stays 0.
- Contention: both requesters active continuously after reset → grants alternate I, D, I, D. A dbus write to 0x100 with be=0xF gets dbus_rvalid as an ack.
- Backpressure / full: OUTST_DEPTH=2, mem_gnt=1, memory withholds rvalid → two grants then mem_req=0. One rvalid arrives → exactly one new grant occurs one cycle later, not in the same cycle.
- Routing: issue I@0x10, then D read @0x200; memory answers 0x11 then 0x22 → ibus_rdata=0x11 and dbus_rdata=0x22, each with a single-cycle rvalid.
- Error: mem_rvalid=1 with nothing outstanding → no rvalid asserted, proto_err=1 and it stays set until rst_n=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
// Holds the transaction owner encoding and the round-robin pick rule.
package mem_arb_pkg;

   typedef enum logic {OWNER_IBUS = 1'b0, OWNER_DBUS = 1'b1} owner_t;

   // Lone requester wins; on contention the one that did not win last time goes.
   function automatic owner_t rr_pick(input logic   ibus_req,
                                      input logic   dbus_req,
                                      input owner_t last_owner);
      if (ibus_req && dbus_req) begin
         return (last_owner == OWNER_IBUS) ? OWNER_DBUS : OWNER_IBUS;
      end
      if (ibus_req) begin
         return OWNER_IBUS;
      end
      return OWNER_DBUS;
   endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Synchronous FIFO recording which requester owns each in-flight memory transaction.
// Push is refused when full; pop is refused when empty.
module arb_owner_fifo
   import mem_arb_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  owner_t           push_owner,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output owner_t           head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   owner_t           slots_q [DEPTH];
   owner_t           slots_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = slots_q[rd_ptr_q];
   assign count = count_q;

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      slots_d  = slots_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         slots_d[wr_ptr_q] = push_owner;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      slots_q <= slots_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the fetch and load/store buses.
// Owners of in-flight transactions are queued so in-order responses return to the right bus.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int OUTST_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ibus_req,
   input  logic [ADDR_W-1:0]   ibus_addr,
   output logic                ibus_gnt,
   output logic                ibus_rvalid,
   output logic [DATA_W-1:0]   ibus_rdata,
   input  logic                dbus_req,
   input  logic                dbus_we,
   input  logic [DATA_W/8-1:0] dbus_be,
   input  logic [ADDR_W-1:0]   dbus_addr,
   input  logic [DATA_W-1:0]   dbus_wdata,
   output logic                dbus_gnt,
   output logic                dbus_rvalid,
   output logic [DATA_W-1:0]   dbus_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                proto_err
);

   localparam int CNT_W = $clog2(OUTST_DEPTH + 1);

   owner_t            sel;
   logic              can_issue;
   logic              xfer;
   logic              pop;
   owner_t            last_owner_q, last_owner_d;
   logic              proto_err_q, proto_err_d;
   logic              ibus_rvalid_q, ibus_rvalid_d;
   logic              dbus_rvalid_q, dbus_rvalid_d;
   logic [DATA_W-1:0] ibus_rdata_q, ibus_rdata_d;
   logic [DATA_W-1:0] dbus_rdata_q, dbus_rdata_d;
   logic              fifo_full;
   logic              fifo_empty;
   owner_t            fifo_head;
   logic [CNT_W-1:0]  fifo_count;

   arb_owner_fifo #(
      .DEPTH(OUTST_DEPTH)
   ) u_owner_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (xfer),
      .push_owner(sel),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   // Issue: fullness comes from the registered count, so a same-cycle pop frees nothing.
   always_comb begin
      sel       = rr_pick(ibus_req, dbus_req, last_owner_q);
      can_issue = (fifo_count < CNT_W'(OUTST_DEPTH));
      mem_req   = rst_n && can_issue && (ibus_req || dbus_req);
      xfer      = mem_req && mem_gnt;
      ibus_gnt  = xfer && (sel == OWNER_IBUS);
      dbus_gnt  = xfer && (sel == OWNER_DBUS);
      mem_we    = 1'b0;
      mem_be    = '1;
      mem_addr  = ibus_addr;
      mem_wdata = '0;
      if (sel == OWNER_DBUS) begin
         mem_we    = dbus_we;
         mem_be    = dbus_be;
         mem_addr  = dbus_addr;
         mem_wdata = dbus_wdata;
      end
      last_owner_d = xfer ? sel : last_owner_q;
   end

   // Response: route to the FIFO head's owner; an unexpected response only raises the error.
   always_comb begin
      pop           = mem_rvalid && !fifo_empty;
      ibus_rvalid_d = pop && (fifo_head == OWNER_IBUS);
      dbus_rvalid_d = pop && (fifo_head == OWNER_DBUS);
      ibus_rdata_d  = ibus_rdata_q;
      dbus_rdata_d  = dbus_rdata_q;
      if (ibus_rvalid_d) begin
         ibus_rdata_d = mem_rdata;
      end
      if (dbus_rvalid_d) begin
         dbus_rdata_d = mem_rdata;
      end
      proto_err_d = proto_err_q || (mem_rvalid && fifo_empty);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_owner_q  <= OWNER_DBUS;
         proto_err_q   <= 1'b0;
         ibus_rvalid_q <= 1'b0;
         dbus_rvalid_q <= 1'b0;
         ibus_rdata_q  <= '0;
         dbus_rdata_q  <= '0;
      end else begin
         last_owner_q  <= last_owner_d;
         proto_err_q   <= proto_err_d;
         ibus_rvalid_q <= ibus_rvalid_d;
         dbus_rvalid_q <= dbus_rvalid_d;
         ibus_rdata_q  <= ibus_rdata_d;
         dbus_rdata_q  <= dbus_rdata_d;
      end
   end

   assign ibus_rvalid = ibus_rvalid_q;
   assign dbus_rvalid = dbus_rvalid_q;
   assign ibus_rdata  = ibus_rdata_q;
   assign dbus_rdata  = dbus_rdata_q;
   assign proto_err   = proto_err_q;

   no_issue_when_full: assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> !mem_req);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level model predicts issue and
// response routing; a monitor pops expected responses from a scoreboard queue.
module tb_mem_bus_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 2;

   logic          clk;
   logic          rst_n;
   logic          ibus_req, ibus_gnt, ibus_rvalid;
   logic [AW-1:0] ibus_addr;
   logic [DW-1:0] ibus_rdata;
   logic          dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
   logic [BW-1:0] dbus_be;
   logic [AW-1:0] dbus_addr;
   logic [DW-1:0] dbus_wdata, dbus_rdata;
   logic          mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [BW-1:0] mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          proto_err;

   mem_bus_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .OUTST_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
      .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
      .dbus_rdata(dbus_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
      int          ready;
   } txn_t;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
      int          due;
   } rsp_t;

   txn_t        inflight[$];
   rsp_t        sb[$];
   logic [31:0] mem_arr [logic [31:0]];

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   bit          mon_en = 1'b0;

   bit          ireq_act, dreq_act, d_we, last_is_d, exp_perr;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic [31:0] exp_irdata, exp_drdata;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit chance(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      w = mem_rd(a);
      for (int b = 0; b < 4; b++) begin
         if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      end
      mem_arr[a] = w;
   endtask

   // Response monitor: a queued response is due exactly one cycle after its mem_rvalid.
   always @(negedge clk) begin : mon
      logic ei, ed;
      rsp_t r;
      if (!mon_en) begin
         sb.delete();
         exp_irdata = '0;
         exp_drdata = '0;
      end else begin
         ei = 1'b0;
         ed = 1'b0;
         if (sb.size() != 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            if (r.is_d) begin
               ed = 1'b1;
               exp_drdata = r.data;
            end else begin
               ei = 1'b1;
               exp_irdata = r.data;
            end
         end
         chk("ibus_rvalid", 64'(ibus_rvalid), 64'(ei));
         chk("dbus_rvalid", 64'(dbus_rvalid), 64'(ed));
         chk("ibus_rdata", 64'(ibus_rdata), 64'(exp_irdata));
         chk("dbus_rdata", 64'(dbus_rdata), 64'(exp_drdata));
      end
   end

   // One clock of stimulus; entered and left at posedge + 1.
   task automatic step(input int p_i, input int p_d, input int p_g, input int p_rv,
                       input int lat_max, input bit spur);
      bit          rv, exp_req, sel_d, g;
      txn_t        t;
      logic [31:0] dat;
      if (!ireq_act && chance(p_i)) begin
         ireq_act = 1'b1;
         i_addr   = {22'd0, 8'($urandom_range(255)), 2'b00};
      end
      if (!dreq_act && chance(p_d)) begin
         dreq_act = 1'b1;
         d_addr   = {22'd0, 8'($urandom_range(255)), 2'b00};
         d_we     = 1'($urandom);
         d_be     = 4'($urandom);
         d_wdata  = $urandom;
      end
      ibus_req   = ireq_act;
      ibus_addr  = i_addr;
      dbus_req   = dreq_act;
      dbus_addr  = d_addr;
      dbus_we    = d_we;
      dbus_be    = d_be;
      dbus_wdata = d_wdata;
      g          = chance(p_g);
      mem_gnt    = g;
      if (spur) rv = (inflight.size() == 0);
      else      rv = (inflight.size() != 0) && (inflight[0].ready <= cyc) && chance(p_rv);
      mem_rvalid = rv;
      mem_rdata  = (rv && inflight.size() != 0) ? inflight[0].data : $urandom;

      exp_req = (inflight.size() < DEPTH) && (ireq_act || dreq_act);
      if (ireq_act && dreq_act) sel_d = !last_is_d;
      else                      sel_d = dreq_act;

      @(negedge clk);
      chk("mem_req", 64'(mem_req), 64'(exp_req));
      chk("ibus_gnt", 64'(ibus_gnt), 64'(exp_req && g && !sel_d));
      chk("dbus_gnt", 64'(dbus_gnt), 64'(exp_req && g && sel_d));
      chk("proto_err", 64'(proto_err), 64'(exp_perr));
      if (exp_req) begin
         chk("mem_addr", 64'(mem_addr), 64'(sel_d ? d_addr : i_addr));
         chk("mem_we", 64'(mem_we), 64'(sel_d && d_we));
         chk("mem_be", 64'(mem_be), 64'(sel_d ? d_be : 4'hF));
         if (sel_d && d_we) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
      end

      if (rv) begin
         if (inflight.size() != 0) begin
            t = inflight.pop_front();
            sb.push_back('{t.is_d, t.data, cyc + 1});
         end else begin
            exp_perr = 1'b1;
         end
      end
      if (exp_req && g) begin
         if (sel_d) begin
            if (d_we) begin
               mem_wr(d_addr, d_wdata, d_be);
               dat = $urandom;
            end else begin
               dat = mem_rd(d_addr);
            end
            dreq_act = 1'b0;
         end else begin
            dat = mem_rd(i_addr);
            ireq_act = 1'b0;
         end
         inflight.push_back('{sel_d, dat, cyc + 1 + int'($urandom_range(lat_max))});
         last_is_d = sel_d;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n, input bit hold_req);
      mon_en     = 1'b0;
      rst_n      = 1'b0;
      ibus_req   = hold_req;
      dbus_req   = hold_req;
      ibus_addr  = 32'h40;
      dbus_addr  = 32'h80;
      dbus_we    = hold_req;
      dbus_be    = 4'hF;
      dbus_wdata = 32'hFFFF_FFFF;
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_mem_req", 64'(mem_req), 64'd0);
         chk("rst_ibus_gnt", 64'(ibus_gnt), 64'd0);
         chk("rst_dbus_gnt", 64'(dbus_gnt), 64'd0);
         chk("rst_ibus_rvalid", 64'(ibus_rvalid), 64'd0);
         chk("rst_dbus_rvalid", 64'(dbus_rvalid), 64'd0);
         chk("rst_ibus_rdata", 64'(ibus_rdata), 64'd0);
         chk("rst_dbus_rdata", 64'(dbus_rdata), 64'd0);
         chk("rst_proto_err", 64'(proto_err), 64'd0);
      end
      inflight.delete();
      ireq_act  = 1'b0;
      dreq_act  = 1'b0;
      last_is_d = 1'b1;
      exp_perr  = 1'b0;
      ibus_req  = 1'b0;
      dbus_req  = 1'b0;
      mem_gnt   = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
   endtask

   initial begin
      int k;
      do_reset(3, 1'b1);
      // Fetch only, memory always ready with latency 1.
      repeat (40) step(100, 0, 100, 100, 0, 1'b0);
      // Both requesters busy; memory withholds responses so the owner FIFO fills.
      repeat (8) step(100, 100, 100, 0, 0, 1'b0);
      repeat (40) step(100, 100, 100, 100, 0, 1'b0);
      // Random traffic, back-pressure and variable latency.
      repeat (1500) step(60, 60, 70, 60, 3, 1'b0);
      // Reset with transactions in flight.
      repeat (20) step(100, 100, 100, 30, 2, 1'b0);
      do_reset(2, 1'b0);
      repeat (150) step(50, 50, 80, 70, 2, 1'b0);
      // Drain everything, then present a response with nothing outstanding.
      k = 0;
      while ((inflight.size() != 0 || sb.size() != 0 || ireq_act || dreq_act) && k < 100) begin
         step(0, 0, 100, 100, 0, 1'b0);
         k++;
      end
      if (k >= 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: still busy after %0d cycles, required idle", k);
      end
      repeat (2) step(0, 0, 100, 100, 0, 1'b0);
      step(0, 0, 100, 100, 0, 1'b1);
      repeat (5) step(0, 0, 100, 100, 0, 1'b0);
      repeat (40) step(50, 50, 80, 70, 2, 1'b0);
      do_reset(2, 1'b1);
      repeat (40) step(60, 60, 80, 70, 2, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

endmodule
